mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
Parametrised N-way, W-bit datapath multiplexer with a configurable registered pipeline, valid tracking, stall/hold, and out-of-range selector detection. It is the successor of the fixed 5-input combinational 32-bit datapath mux. It serves datapath muxes in the multicycle CPU (ALU source, PC source, write-data select) wherever a registered select path is needed to close timing. Inputs arrive as one flat bus, so a single module covers every mux width and input count in the datapath.

Parameters:
WIDTH, 32, data width of each input and of the output.
NUM_INPUTS, 5, number of data inputs; legal range 2..16.
SEL_WIDTH, 3, selector width; must satisfy 2**SEL_WIDTH >= NUM_INPUTS.
PIPE_STAGES, 1, register stages between input and output; legal range 1..4.
DEFAULT_VALUE, 0, WIDTH-bit value driven for an out-of-range selector.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
selector  input  SEL_WIDTH  input index; input k occupies bits [k*WIDTH +: WIDTH] of inputs_flat.
inputs_flat  input  NUM_INPUTS*WIDTH  concatenated data inputs.
in_valid  input  1  current selector/inputs form a sample to capture.
stall  input  1  freeze the whole pipeline.
clear_error  input  1  clears sel_error and bad_sel.
output_final  output  WIDTH  selected data after PIPE_STAGES cycles.
out_valid  output  1  output_final holds a captured sample.
sel_error  output  1  sticky: a valid sample carried an out-of-range selector.
bad_sel  output  SEL_WIDTH  selector value of the most recent out-of-range valid sample.

Behaviour:
- Reset (reset=1 at a rising edge): all stage data registers = 0, all stage valid bits = 0, output_final=0, out_valid=0, sel_error=0, bad_sel=0. Reset has priority over stall, in_valid and clear_error. Reset mid-pipeline discards all in-flight samples.
- Combinational select:
  - sel_hit = selector < NUM_INPUTS.
  - mux_out = inputs_flat slice at selector when sel_hit, otherwise DEFAULT_VALUE.
- Stage 0 capture, when stall=0:
  - valid0 <= in_valid.
  - data0 <= mux_out if in_valid=1; otherwise data0 holds its previous value.
- Stage i (1..PIPE_STAGES-1), when stall=0: valid_i <= valid_(i-1); data_i <= data_(i-1).
- Stall: when stall=1, every data and valid register holds. in_valid and selector are ignored that cycle, so the sample is dropped and the upstream logic must keep it.
- Outputs: output_final and out_valid are the last stage registers, with no combinational path from any input.
- Latency: a sample accepted at edge t (in_valid=1, stall=0) appears at edge t+PIPE_STAGES-1 plus one cycle per stalled edge in between. PIPE_STAGES=1 therefore gives output on the cycle after capture.
- Throughput: one sample per unstalled cycle. Back-to-back samples keep their order and are neither lost nor duplicated.
- Error tracking is evaluated at stage-0 capture, i.e. when stall=0 and in_valid=1:
  - If sel_hit=0: sel_error <= 1 and bad_sel <= selector.
  - The error sample still flows down the pipe carrying DEFAULT_VALUE with valid=1.
- clear_error=1: sel_error <= 0 and bad_sel <= 0 on the next edge. clear_error works during stall.
- Simultaneous clear_error and a new out-of-range capture: the set wins, so sel_error=1 and bad_sel = the new selector.
- An out-of-range selector with in_valid=0 does not set the error and does not change data0.
- When NUM_INPUTS = 2**SEL_WIDTH, sel_hit is always 1 and sel_error stays at 0.
- Parameter check: elaboration fails (via a generate-time error) if NUM_INPUTS > 2**SEL_WIDTH, NUM_INPUTS < 2, or PIPE_STAGES is outside 1..4.

Test Plan:
- Reset then sweep: use defaults with input k = 32'hA000_0000+k and in_valid=1, selector 0..4 on consecutive cycles. Required: output_final = A0000000..A0000004 on the cycles after capture, out_valid=1 throughout, sel_error=0.
- Out-of-range: selector=6, in_valid=1, one cycle. Required: next cycle output_final=0, out_valid=1, sel_error=1, bad_sel=6; sel_error stays 1 over 10 further cycles of legal traffic. Then pulse clear_error: sel_error=0, bad_sel=0.
- Set-wins race: assert clear_error in the same cycle as a capture with selector=7 and sel_error already 1. Required: sel_error=1 and bad_sel=7 afterwards.
- Pipeline and stall: set PIPE_STAGES=3 and capture samples for selectors 1, 2, 3 back to back, then stall=1 for 4 cycles starting the cycle after the last capture. Required: output_final/out_valid frozen during the stall, values A0000001/2/3 emerge in order after release, and total latency = 3 + 4.
- Bubble handling: alternate in_valid 1/0 with selector=4. Required: out_valid alternates 1/0 delayed by PIPE_STAGES, and output_final holds A0000004 across bubble cycles.
- Reset mid-flight: PIPE_STAGES=4 with 3 samples in flight and sel_error=1; assert reset for one cycle. Required: all outputs 0 on the next cycle, no stale sample ever appears with out_valid=1, and the first sample captured after reset emerges exactly 4 cycles later.

Source files
------------

// File: rtl/mux_n_pipe.sv
// N-way, W-bit datapath mux with a registered pipeline, valid tracking,
// stall/hold and sticky out-of-range selector detection.
module mux_n_pipe #(
   parameter int               WIDTH         = 32,
   parameter int               NUM_INPUTS    = 5,
   parameter int               SEL_WIDTH     = 3,
   parameter int               PIPE_STAGES   = 1,
   parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SEL_WIDTH-1:0]        selector,
   input  logic [NUM_INPUTS*WIDTH-1:0] inputs_flat,
   input  logic                        in_valid,
   input  logic                        stall,
   input  logic                        clear_error,
   output logic [WIDTH-1:0]            output_final,
   output logic                        out_valid,
   output logic                        sel_error,
   output logic [SEL_WIDTH-1:0]        bad_sel
);

   generate
      if (NUM_INPUTS < 2 || NUM_INPUTS > (1 << SEL_WIDTH) ||
          PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_param_check
         $error("mux_n_pipe: illegal NUM_INPUTS/SEL_WIDTH/PIPE_STAGES combination");
      end
   endgenerate

   logic                              sel_hit;
   logic [WIDTH-1:0]                  mux_out;
   logic [PIPE_STAGES-1:0]            vld_pipe;
   logic [PIPE_STAGES-1:0][WIDTH-1:0] data_pipe;

   always_comb begin
      sel_hit = 1'b0;
      mux_out = DEFAULT_VALUE;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (int'(selector) == k) begin
            sel_hit = 1'b1;
            mux_out = inputs_flat[k*WIDTH +: WIDTH];
         end
      end
   end

   // Stage 0 holds its data across bubbles so output_final stays stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else if (!stall) begin
         vld_pipe[0] <= in_valid;
         if (in_valid) data_pipe[0] <= mux_out;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   // A new out-of-range capture wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_error <= 1'b0;
         bad_sel   <= '0;
      end else if (!stall && in_valid && !sel_hit) begin
         sel_error <= 1'b1;
         bad_sel   <= selector;
      end else if (clear_error) begin
         sel_error <= 1'b0;
         bad_sel   <= '0;
      end
   end

   assign output_final = data_pipe[PIPE_STAGES-1];
   assign out_valid    = vld_pipe[PIPE_STAGES-1];

endmodule
